load_store_unit: RTL and testbench

//  Memory-access stage directly downstream of the ALU. Takes the ALU effective address
//  (op1+op2 for LB/LH/LW/LBU/LHU/SB/SH/SW alucodes) and the rs2 store data.

---
 rtl/load_store_unit_pkg.sv | 88 ++++++++
 rtl/load_store_unit_if.sv | 24 ++
 rtl/load_store_unit_load_align.sv | 38 +++
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: ALU memory opcodes, FSM state codes,
// the decoded operation record and the lane/byte-enable helpers.
package load_store_unit_pkg;

    localparam logic [5:0] ALU_LB  = 6'd16;
    localparam logic [5:0] ALU_LH  = 6'd17;
    localparam logic [5:0] ALU_LW  = 6'd18;
    localparam logic [5:0] ALU_LBU = 6'd19;
    localparam logic [5:0] ALU_LHU = 6'd20;
    localparam logic [5:0] ALU_SB  = 6'd21;
    localparam logic [5:0] ALU_SH  = 6'd22;
    localparam logic [5:0] ALU_SW  = 6'd23;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic  is_load;
        logic  is_signed;
        size_e size;
    } mem_op_t;

    function automatic logic is_mem_op(input logic [5:0] code);
        return code inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
                            ALU_SB, ALU_SH, ALU_SW};
    endfunction

    function automatic mem_op_t decode_op(input logic [5:0] code);
        mem_op_t op;
        op = '{is_load: 1'b0, is_signed: 1'b0, size: SZ_WORD};
        case (code)
            ALU_LB:  op = '{is_load: 1'b1, is_signed: 1'b1, size: SZ_BYTE};
            ALU_LH:  op = '{is_load: 1'b1, is_signed: 1'b1, size: SZ_HALF};
            ALU_LW:  op = '{is_load: 1'b1, is_signed: 1'b0, size: SZ_WORD};
            ALU_LBU: op = '{is_load: 1'b1, is_signed: 1'b0, size: SZ_BYTE};
            ALU_LHU: op = '{is_load: 1'b1, is_signed: 1'b0, size: SZ_HALF};
            ALU_SB:  op = '{is_load: 1'b0, is_signed: 1'b0, size: SZ_BYTE};
            ALU_SH:  op = '{is_load: 1'b0, is_signed: 1'b0, size: SZ_HALF};
            default: op = '{is_load: 1'b0, is_signed: 1'b0, size: SZ_WORD};
        endcase
        return op;
    endfunction

    // Halfword and word accesses ignore the low address bits below their size.
    function automatic logic [1:0] align_lo(input size_e size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return a;
            SZ_HALF: return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e size, input logic [1:0] a);
        case (size)
            SZ_HALF: return a[0];
            SZ_WORD: return |a;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input size_e size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 4'b0001 << a;
            SZ_HALF: return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input size_e size, input logic [31:0] sd);
        case (size)
            SZ_BYTE: return {4{sd[7:0]}};
            SZ_HALF: return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave):
// req/gnt address phase followed by a single rvalid response.
interface load_store_unit_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/load_store_unit_load_align.sv
// Load lane selection: picks the addressed byte/halfword out of the read word
// and sign- or zero-extends it to 32 bits.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  size_e       i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_addr_lo,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_size)
            SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: issues one data-memory transaction per accepted request and
// returns extended load data. Define MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [5:0]               i_alucode,
    input  logic [31:0]              i_addr,
    input  logic [31:0]              i_store_data,
    input  logic [4:0]               i_rd_in,
    load_store_unit_if.master        bus,
    output logic                     o_out_valid,
    output logic                     o_out_load,
    output logic [4:0]               o_out_rd,
    output logic [31:0]              o_out_data,
    output logic                     o_out_err
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    mem_op_t     r_op;
    logic [1:0]  r_addr_lo;
    logic [4:0]  r_rd;
    logic [7:0]  r_cnt;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic        r_out_load;
    logic [4:0]  r_out_rd;
    logic [31:0] r_out_data;
    logic        r_out_err;

    logic [1:0]  w_next_state;
    mem_op_t     w_in_op;
    logic [1:0]  w_in_lo;
    logic        w_accept;
    logic        w_trap;
    logic        w_resp_ok;
    logic        w_timeout;
    logic [31:0] w_load_data;

    assign w_in_op  = decode_op(i_alucode);
    assign w_in_lo  = align_lo(w_in_op.size, i_addr[1:0]);
    assign w_accept = (r_state == ST_IDLE) && i_in_valid && is_mem_op(i_alucode);

`ifdef MISALIGN_TRAP_EN
    assign w_trap = w_accept && is_misaligned(w_in_op.size, i_addr[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    // A response with the grant completes the transaction; in WAIT, rvalid beats the timeout.
    assign w_resp_ok = bus.mem_rvalid &&
                       (((r_state == ST_REQ) && bus.mem_gnt) || (r_state == ST_WAIT));
    assign w_timeout = (r_state == ST_WAIT) && !bus.mem_rvalid && (r_cnt == TIMEOUT_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_trap)        w_next_state = ST_RESP;
                else if (w_accept) w_next_state = ST_REQ;
            end
            ST_REQ: begin
                if (bus.mem_gnt) w_next_state = bus.mem_rvalid ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (w_resp_ok || w_timeout) w_next_state = ST_RESP;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= (r_state == ST_WAIT) ? r_cnt + 8'd1 : 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= '{is_load: DISABLE, is_signed: DISABLE, size: SZ_WORD};
            r_addr_lo   <= '0;
            r_rd        <= '0;
            r_mem_we    <= DISABLE;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
        end else if (w_accept) begin
            r_op      <= w_in_op;
            r_addr_lo <= w_in_lo;
            r_rd      <= i_rd_in;
            if (!w_trap) begin
                r_mem_we    <= !w_in_op.is_load;
                r_mem_addr  <= {i_addr[31:2], 2'b00};
                r_mem_be    <= byte_enables(w_in_op.size, w_in_lo);
                r_mem_wdata <= store_lanes(w_in_op.size, i_store_data);
            end
        end
    end

    lsu_load_align u_load_align (
        .i_rdata   (bus.mem_rdata),
        .i_size    (r_op.size),
        .i_signed  (r_op.is_signed),
        .i_addr_lo (r_addr_lo),
        .o_data    (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_load <= DISABLE;
            r_out_rd   <= '0;
            r_out_data <= '0;
            r_out_err  <= DISABLE;
        end else if (w_trap) begin
            r_out_load <= w_in_op.is_load;
            r_out_rd   <= i_rd_in;
            r_out_data <= '0;
            r_out_err  <= ENABLE;
        end else if (w_resp_ok || w_timeout) begin
            r_out_load <= r_op.is_load;
            r_out_rd   <= r_rd;
            r_out_data <= (w_resp_ok && r_op.is_load) ? w_load_data : 32'd0;
            r_out_err  <= w_timeout;
        end
    end

    assign o_in_ready     = (r_state == ST_IDLE);
    assign bus.mem_req    = (r_state == ST_REQ);
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_be     = r_mem_be;
    assign bus.mem_wdata  = r_mem_wdata;
    assign o_out_valid    = (r_state == ST_RESP);
    assign o_out_load     = r_out_load;
    assign o_out_rd       = r_out_rd;
    assign o_out_data     = r_out_data;
    assign o_out_err      = r_out_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of load/store vectors with
// bus timing per entry, plus hand-written timeout, reset and reject sequences.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  alucode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        out_valid;
    logic        out_load;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_err;

    int total = 0;
    int bad   = 0;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_alucode    (alucode),
        .i_addr       (addr),
        .i_store_data (store_data),
        .i_rd_in      (rd_in),
        .bus          (bus),
        .o_out_valid  (out_valid),
        .o_out_load   (out_load),
        .o_out_rd     (out_rd),
        .o_out_data   (out_data),
        .o_out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          gnt_cyc;
        int          rv_dly;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [5:0] op, input logic [31:0] a,
                                input logic [31:0] sd, input logic [4:0] rd,
                                input logic [31:0] rdata, input int gc, input int rv,
                                input logic [31:0] e_addr, input logic [3:0] e_be,
                                input logic [31:0] e_wdata, input logic [31:0] e_data);
        vec_t v;
        v.name = nm;  v.op = op;  v.addr = a;  v.sd = sd;  v.rd = rd;  v.rdata = rdata;
        v.gnt_cyc = gc;  v.rv_dly = rv;
        v.e_we = op inside {ALU_SB, ALU_SH, ALU_SW};
        v.e_addr = e_addr;  v.e_be = e_be;  v.e_wdata = e_wdata;  v.e_data = e_data;
        return v;
    endfunction

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd);
        @(negedge clk);
        in_valid = 1'b1;  alucode = op;  addr = a;  store_data = sd;  rd_in = rd;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Issues one vector, plays the memory side, and checks request and response.
    task automatic run_vec(input vec_t v);
        int reqs;
        reqs = 0;
        check({v.name, " ready"}, in_ready, 1'b1);
        issue(v.op, v.addr, v.sd, v.rd);
        check({v.name, " req"}, bus.mem_req, 1'b1);
        check({v.name, " we"}, bus.mem_we, v.e_we);
        check({v.name, " addr"}, bus.mem_addr, v.e_addr);
        if (v.e_we) begin
            check({v.name, " be"}, bus.mem_be, v.e_be);
            check({v.name, " wdata"}, bus.mem_wdata, v.e_wdata);
        end
        for (int c = 1; c <= v.gnt_cyc; c++) begin
            if (bus.mem_req) reqs++;
            if (c == v.gnt_cyc) begin
                bus.mem_gnt = 1'b1;
                if (v.rv_dly == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = v.rdata;
                end
            end else begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'hBAD0_BAD0;
            end
            @(negedge clk);
            bus.mem_gnt = 1'b0;  bus.mem_rvalid = 1'b0;  bus.mem_rdata = '0;
        end
        check({v.name, " req cycles"}, reqs, v.gnt_cyc);
        check({v.name, " req dropped"}, bus.mem_req, 1'b0);
        for (int i = 1; i <= v.rv_dly; i++) begin
            if (i == v.rv_dly) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = v.rdata;
            end
            @(negedge clk);
            bus.mem_rvalid = 1'b0;  bus.mem_rdata = '0;
        end
        check({v.name, " out_valid"}, out_valid, 1'b1);
        check({v.name, " out_data"}, out_data, v.e_data);
        check({v.name, " out_load"}, out_load, !v.e_we);
        check({v.name, " out_rd"}, out_rd, v.rd);
        check({v.name, " out_err"}, out_err, 1'b0);
        @(negedge clk);
        check({v.name, " single pulse"}, out_valid, 1'b0);
        check({v.name, " back idle"}, in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0;  in_valid = 1'b0;  alucode = '0;  addr = '0;  store_data = '0;  rd_in = '0;
        bus.mem_gnt = 1'b0;  bus.mem_rvalid = 1'b0;  bus.mem_rdata = '0;

        vecs[0]  = mk("LB 103",   ALU_LB,  32'h103, 32'h0,        5'd5,  32'h8011_2233, 1, 0, 32'h100, 4'h0, 32'h0,        32'hFFFF_FF80);
        vecs[1]  = mk("LHU 102",  ALU_LHU, 32'h102, 32'h0,        5'd6,  32'hBEEF_1234, 1, 1, 32'h100, 4'h0, 32'h0,        32'h0000_BEEF);
        vecs[2]  = mk("SB 201",   ALU_SB,  32'h201, 32'h0000_00A5, 5'd0, 32'h0,         2, 0, 32'h200, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        vecs[3]  = mk("LH 100",   ALU_LH,  32'h100, 32'h0,        5'd7,  32'h1234_8001, 1, 3, 32'h100, 4'h0, 32'h0,        32'hFFFF_8001);
        vecs[4]  = mk("LBU 102",  ALU_LBU, 32'h102, 32'h0,        5'd8,  32'h11C3_4455, 2, 1, 32'h100, 4'h0, 32'h0,        32'h0000_00C3);
        vecs[5]  = mk("LW 302",   ALU_LW,  32'h302, 32'h0,        5'd9,  32'hDEAD_BEEF, 1, 0, 32'h300, 4'h0, 32'h0,        32'hDEAD_BEEF);
        vecs[6]  = mk("SH 406",   ALU_SH,  32'h406, 32'h1234_ABCD, 5'd0, 32'h0,         1, 2, 32'h404, 4'b1100, 32'hABCD_ABCD, 32'h0);
        vecs[7]  = mk("SW 508",   ALU_SW,  32'h508, 32'hCAFE_F00D, 5'd3, 32'h0,         3, 2, 32'h508, 4'b1111, 32'hCAFE_F00D, 32'h0);
        vecs[8]  = mk("LH 103",   ALU_LH,  32'h103, 32'h0,        5'd10, 32'h7FFE_0000, 1, 0, 32'h100, 4'h0, 32'h0,        32'h0000_7FFE);
        vecs[9]  = mk("SB 003",   ALU_SB,  32'h003, 32'hFFFF_FF5A, 5'd0, 32'h0,         1, 1, 32'h000, 4'b1000, 32'h5A5A_5A5A, 32'h0);
        vecs[10] = mk("LB 000",   ALU_LB,  32'h000, 32'h0,        5'd31, 32'h0000_007F, 1, 0, 32'h000, 4'h0, 32'h0,        32'h0000_007F);
        vecs[11] = mk("LHU 000",  ALU_LHU, 32'h000, 32'h0,        5'd1,  32'hFFFF_8000, 2, 2, 32'h000, 4'h0, 32'h0,        32'h0000_8000);

        repeat (2) @(negedge clk);
        check("rst in_ready", in_ready, 1'b1);
        check("rst mem_req", bus.mem_req, 1'b0);
        check("rst mem_we", bus.mem_we, 1'b0);
        check("rst mem_addr", bus.mem_addr, 32'h0);
        check("rst mem_be", bus.mem_be, 4'h0);
        check("rst mem_wdata", bus.mem_wdata, 32'h0);
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_load", out_load, 1'b0);
        check("rst out_rd", out_rd, 5'd0);
        check("rst out_data", out_data, 32'h0);
        check("rst out_err", out_err, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Non-memory alucode is dropped without touching the bus.
        issue(6'd0, 32'h700, 32'h0, 5'd4);
        check("nonmem ready", in_ready, 1'b1);
        check("nonmem req", bus.mem_req, 1'b0);
        @(negedge clk);
        check("nonmem no out", out_valid, 1'b0);

        // Timeout: granted but never answered.
        issue(ALU_LW, 32'h800, 32'h0, 5'd12);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout cycles", n, 16);
        check("timeout valid", out_valid, 1'b1);
        check("timeout err", out_err, 1'b1);
        check("timeout data", out_data, 32'h0);
        @(negedge clk);
        check("timeout idle", in_ready, 1'b1);

        // rvalid on the last allowed WAIT cycle still completes normally.
        issue(ALU_LW, 32'h900, 32'h0, 5'd13);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        repeat (15) @(negedge clk);
        check("lastcnt pending", out_valid, 1'b0);
        bus.mem_rvalid = 1'b1;  bus.mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;  bus.mem_rdata = '0;
        check("lastcnt valid", out_valid, 1'b1);
        check("lastcnt err", out_err, 1'b0);
        check("lastcnt data", out_data, 32'h1357_9BDF);
        @(negedge clk);

        // Reset in REQ: request drops at once, late response is ignored.
        issue(ALU_LW, 32'hA00, 32'h0, 5'd14);
        check("midrst req before", bus.mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst req dropped", bus.mem_req, 1'b0);
        check("midrst ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_rvalid = 1'b1;  bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;  bus.mem_rdata = '0;
        check("midrst late rvalid", out_valid, 1'b0);
        check("midrst idle", in_ready, 1'b1);
        check("midrst out_data", out_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
